// File: rtl/mvp_pkg.sv
// mvp_pkg: FSM state type and arithmetic helpers shared by mat_vec_prod_seq.
// Defining MVP_SATURATE_EN makes the result clamp instead of wrap.
package mvp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  // Width of the intermediate value handed to reduce_result.
  localparam int RED_W = 64;

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  // Reduce a sign-extended shifted accumulator to w significant bits.
  function automatic logic signed [RED_W-1:0] reduce_result(input logic signed [RED_W-1:0] v,
                                                            input int w);
`ifdef MVP_SATURATE_EN
    logic signed [RED_W-1:0] hi;
    logic signed [RED_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return v & ((64'sd1 <<< w) - 64'sd1);
`endif
  endfunction

endpackage

// File: rtl/mvp_mac.sv
// mvp_mac: registered signed multiply-accumulate with clear and enable.
// acc_nxt exposes the value the accumulator takes on the coming edge.
module mvp_mac #(
  parameter int W     = 16,
  parameter int ACC_W = 34
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] acc_nxt
);

  logic signed [2*W-1:0]   prod_p0;
  logic signed [ACC_W-1:0] acc_p1;

  assign prod_p0 = a * b;

  always_comb begin
    acc_nxt = acc_p1;
    if (clr)
      acc_nxt = '0;
    else if (en)
      acc_nxt = acc_p1 + ACC_W'(prod_p0);
  end

  // stage p0 -> p1: accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_p1 <= '0;
    else
      acc_p1 <= acc_nxt;
  end

endmodule

// File: rtl/mat_vec_prod_seq.sv
// mat_vec_prod_seq: y = A*x with one MAC per cycle and valid/ready on every port.
// Build option MVP_SATURATE_EN clamps each y element instead of wrapping it.
module mat_vec_prod_seq
  import mvp_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [N*W-1:0]      vec_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic signed [W-1:0] a_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic signed [W-1:0] y_data,
  output logic                y_last,
  output logic                busy
);

  localparam int ACC_W = acc_width(W, N);
  localparam int CNT_W = $clog2(N);

  state_t                  state;
  logic [CNT_W-1:0]        row;
  logic [CNT_W-1:0]        col;
  logic signed [W-1:0]     xreg [N];
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] acc_shift;
  logic                    mac_clr;
  logic                    mac_en;

  assign vec_ready = (state == IDLE);
  assign mac_clr   = (state != RUN);
  assign mac_en    = (state == RUN) && a_valid;
  // acc_nxt already holds the final product on the cycle col N-1 is accepted
  assign acc_shift = acc_nxt >>> FRAC;

  mvp_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (a_data),
    .b       (xreg[col]),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (vec_ready && vec_valid)
      for (int j = 0; j < N; j++)
        xreg[j] <= vec_data[j*W +: W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      a_ready <= 1'b0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (vec_valid) begin
          state   <= RUN;
          row     <= '0;
          col     <= '0;
          a_ready <= 1'b1;
          busy    <= 1'b1;
        end
        RUN: if (a_valid) begin
          if (col == CNT_W'(N - 1)) begin
            state   <= OUT;
            col     <= '0;
            a_ready <= 1'b0;
            y_valid <= 1'b1;
            y_data  <= W'(reduce_result(RED_W'(acc_shift), W));
            y_last  <= (row == CNT_W'(N - 1));
          end else begin
            col <= col + 1'b1;
          end
        end
        OUT: if (y_ready) begin
          y_valid <= 1'b0;
          if (row == CNT_W'(N - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            row     <= row + 1'b1;
            state   <= RUN;
            a_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mat_vec_prod_seq.md
# mat_vec_prod_seq

Sequential, parametrised successor to the 4x4 combinational matrix-vector product. It computes y = A·x for an N×N signed fixed-point matrix A and an N-element vector x using one multiply-accumulate per cycle, with valid/ready handshakes on every port. It sits between the matrix-element streamer and the result consumer in the accelerator datapath. It replaces the flat combinational array: DSP cost drops to one multiplier, and the block supports backpressure.

## Interface
- N, default 4: matrix dimension (rows = cols = N), N ≥ 2.
- W, default 16: element width, signed two's complement.
- FRAC, default 8: fractional bits (Q(W-FRAC).FRAC) of x, A and y.
- clk  in  1: single clock, all logic on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- vec_valid  in  1: vector x is offered.
- vec_ready  out  1: block can capture x.
- vec_data  in  N*W: x, element j at bits [j*W +: W].
- a_valid  in  1: matrix element offered, row-major order.
- a_ready  out  1: element accepted when a_valid & a_ready.
- a_data  in  W: element A[row][col].
- y_valid  out  1: result element y[row] is available.
- y_ready  in  1: consumer accepts y on y_valid & y_ready.
- y_data  out  W: y[row].
- y_last  out  1: high with y_valid for row N-1.
- busy  out  1: high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, RUN and OUT.
- IDLE:
  - vec_ready = 1.
  - On vec_valid, the block latches vec_data into a register file, clears row/col counters and the accumulator, and moves to RUN.
- RUN:
  - a_ready = 1.
  - Each accepted element adds a_data × x[col] to the accumulator, then col increments.
  - Accepting col = N-1 moves the FSM to OUT. The final product is included in the accumulator.
- OUT:
  - y_valid = 1.
  - y_data = the scaled accumulator, registered and held stable until accepted.
  - When y_ready is high:
    - if row < N-1: row increments, col and accumulator clear, and the FSM returns to RUN;
    - if row = N-1: the FSM returns to IDLE.
- Arithmetic:
  - Each product is 2W bits.
  - The accumulator is 2W + $clog2(N) bits, so it never overflows internally.
  - The result is the accumulator arithmetically shifted right by FRAC (truncation toward −∞), then reduced to W bits per the configuration.
- Handshake rules:
  - vec_ready, a_ready and y_valid are mutually exclusive.
  - a_valid low in RUN stalls the block with no state change.
  - y_ready low in OUT stalls the block, and a_ready stays 0.
  - vec_valid while not IDLE is ignored; x is never overwritten mid-product.

## Timing
- Reset values:
  - state = IDLE;
  - vec_ready = 1 (combinational from state);
  - a_ready = 0, y_valid = 0, y_data = 0, y_last = 0, busy = 0;
  - counters and accumulator = 0.
- Latency:
  - y_valid rises on the clock edge after the handshake of element (row, N-1).
  - With no stalls, a full product takes 1 + N·(N+1) cycles from the vector handshake to the last y handshake.
- A back-to-back vector is accepted in the cycle after the final y handshake (IDLE).
- Reset asserted mid-operation:
  - All outputs immediately take their reset values; the partial result is discarded.
  - After deassertion, the next vec handshake starts a clean product.
- y_data and y_last change only on the transition into OUT.

## Configuration
- MVP_SATURATE_EN defined: the shifted result is clamped to [−2^(W-1), 2^(W-1)−1]. For W = 16 this is 0x8000..0x7FFF.
- MVP_SATURATE_EN undefined: the low W bits of the shifted result are taken (wrap-around), and no saturation logic is built.

## Structure
- Package mvp_pkg holds:
  - the state enum typedef (IDLE, RUN, OUT);
  - the accumulator-width localparam function;
  - the sat/truncate function, guarded by MVP_SATURATE_EN.
- Sub-module mvp_mac contains:
  - a registered signed multiply-accumulate with clear and enable inputs;
  - parameter W, and an ACC_W output width.
- The top level holds the FSM, the counters, the x register file and the output register.

## Test plan
All scenarios use N=4, W=16, FRAC=8.
1. Identity:
   - A = I (0x0100 on the diagonal), x = {0x0100, 0x0200, 0xFD00, 0x0080}.
   - Expect y = 0x0100, 0x0200, 0xFD00, 0x0080, with y_last only on the 4th.
2. Mixed signs:
   - Row 0 = {0x0200, 0xFF00, 0, 0}, x = {0x0300, 0x0100, 0, 0}.
   - Expect y[0] = 0x0500 (2·3 − 1 = 5.0).
3. Overflow:
   - All A and x elements = 0x7F00.
   - With MVP_SATURATE_EN, every y = 0x7FFF.
   - Without it, every y = 0x0400. Accumulator = 4·127² = 64516.0, and its scaled value truncated to 16 bits gives 0x0400.
4. Backpressure:
   - Hold y_ready low for 5 cycles at row 1.
   - Expect y_valid to stay high, y_data to be stable, and a_ready = 0 throughout; row 2 resumes after acceptance.
5. Input gaps and ignored vector:
   - Drop a_valid on random cycles and pulse vec_valid while busy.
   - Expect results identical to scenario 1 and vec_ready = 0 while busy.
6. Reset mid-row:
   - Assert rst_n = 0 after 6 elements.
   - Expect all outputs at reset values at once; a subsequent full identity run gives the scenario-1 results.
